// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: widths and FSM state encoding.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int LEVEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus registered edge detector. q is the synchronized
// level delayed so that it lines up with the rise/fall pulses.
module pwm_edge_sync (
  input  logic CLK,
  input  logic Reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic sync_1;
  logic sync_2;

  // Synchronize the asynchronous line and register edge pulses against the delayed level.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      q      <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_1 <= d;
      sync_2 <= sync_1;
      q      <= sync_2;
      rise   <= sync_2 & ~q;
      fall   <= ~sync_2 & q;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time between rising edges of an
// asynchronous PWM line, decodes an 8-level duty value and flags a stuck line.
//
//   state   | meaning
//   IDLE    | after reset, waiting for the first rising edge to start a period
//   MEASURE | counting period/high time; each rising edge publishes a result
//   STUCK   | no rising edge for TIMEOUT cycles; counters frozen until next edge
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               PWM_in,
  output logic [LEVEL_W-1:0] Level,
  output logic [CNT_W-1:0]   Period,
  output logic [CNT_W-1:0]   High,
  output logic               Valid,
  output logic               Stuck
);

  localparam int             XW        = CNT_W + 3;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic               q_sync;
  logic               rise_det;
  logic               fall_det_unused;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   per_cnt, per_nxt;
  logic [CNT_W-1:0]   hi_cnt, hi_nxt;
  logic [LEVEL_W-1:0] level_nxt, lvl;
  logic [CNT_W-1:0]   period_nxt, high_nxt;
  logic               valid_nxt, stuck_nxt;
  logic [XW-1:0]      hi_x8, per_x;

  // The falling edge is not needed here: high time is accumulated from the level.
  pwm_edge_sync u_sync (
    .CLK   (CLK),
    .Reset (Reset),
    .d     (PWM_in),
    .q     (q_sync),
    .rise  (rise_det),
    .fall  (fall_det_unused)
  );

  // Duty decode: count how many thresholds k*Period the scaled high time reaches.
  always_comb begin
    hi_x8 = {hi_cnt, 3'b000};
    per_x = {3'b000, per_cnt};
    lvl   = '0;
    for (int k = 1; k < (1 << LEVEL_W); k++) begin
      if (hi_x8 >= per_x * XW'(k)) lvl = LEVEL_W'(k);
    end
  end

  // Next-state, counter and output-register values.
  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    hi_nxt     = hi_cnt;
    level_nxt  = Level;
    period_nxt = Period;
    high_nxt   = High;
    valid_nxt  = 1'b0;
    stuck_nxt  = Stuck;
    unique case (state)
      IDLE: begin
        if (rise_det) begin
          per_nxt   = CNT_W'(1);
          hi_nxt    = CNT_W'(1);
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        // A rising edge takes priority over an expiring timeout in the same cycle.
        if (rise_det) begin
          period_nxt = per_cnt;
          high_nxt   = hi_cnt;
          level_nxt  = lvl;
          valid_nxt  = 1'b1;
          per_nxt    = CNT_W'(1);
          hi_nxt     = CNT_W'(1);
        end else if (per_cnt >= TIMEOUT_C) begin
          state_nxt = STUCK;
          stuck_nxt = 1'b1;
          level_nxt = {LEVEL_W{q_sync}};
          valid_nxt = 1'b1;
        end else begin
          per_nxt = per_cnt + CNT_W'(1);
          hi_nxt  = hi_cnt + CNT_W'(q_sync);
        end
      end
      STUCK: begin
        if (rise_det) begin
          stuck_nxt = 1'b0;
          per_nxt   = CNT_W'(1);
          hi_nxt    = CNT_W'(1);
          state_nxt = MEASURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      Level   <= '0;
      Period  <= '0;
      High    <= '0;
      Valid   <= 1'b0;
      Stuck   <= 1'b0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
      Level   <= level_nxt;
      Period  <= period_nxt;
      High    <= high_nxt;
      Valid   <= valid_nxt;
      Stuck   <= stuck_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a scoreboard of expected results is
// filled as PWM periods are driven and drained on every Valid pulse.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TO    = 1000;
  localparam int LAT   = 4;

  logic             CLK;
  logic             Reset;
  logic             PWM_in;
  logic [2:0]       Level;
  logic [CNT_W-1:0] Period;
  logic [CNT_W-1:0] High;
  logic             Valid;
  logic             Stuck;

  typedef struct {
    int     period;
    int     high;
    int     level;
    int     stuck;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   pend;
  bit     pend_ok;
  int     last_per;
  int     last_hi;
  longint cyc;
  int     n_cmp;
  int     n_err;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .PWM_in (PWM_in),
    .Level  (Level),
    .Period (Period),
    .High   (High),
    .Valid  (Valid),
    .Stuck  (Stuck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Push the measurement of the previous period when its closing edge is driven.
  task automatic push_pending(input longint k);
    if (pend_ok) begin
      pend.cyc = k + LAT;
      sb.push_back(pend);
      last_per = pend.period;
      last_hi  = pend.high;
    end
  endtask

  task automatic drive_period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge CLK);
      PWM_in = (i < h);
      if (i == 0) begin
        push_pending(cyc);
        pend    = '{period: p, high: h, level: (8 * h) / p, stuck: 0, cyc: 0};
        pend_ok = 1'b1;
      end
    end
  endtask

  task automatic drive_stuck_high();
    exp_t e;
    @(negedge CLK);
    PWM_in = 1'b1;
    push_pending(cyc);
    pend_ok = 1'b0;
    e = '{period: last_per, high: last_hi, level: 7, stuck: 1, cyc: cyc + LAT + TO};
    sb.push_back(e);
    repeat (TO + 10) @(negedge CLK);
    chk("stuck_hold", Stuck, 1);
    PWM_in = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_level"},  Level,  0);
    chk({pfx, "_period"}, Period, 0);
    chk({pfx, "_high"},   High,   0);
    chk({pfx, "_valid"},  Valid,  0);
    chk({pfx, "_stuck"},  Stuck,  0);
  endtask

  // Every Valid must match the oldest expectation, including its cycle.
  always @(negedge CLK) begin
    if (Reset && Valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_cyc", cyc,    e.cyc);
        chk("period",    Period, e.period);
        chk("high",      High,   e.high);
        chk("level",     Level,  e.level);
        chk("stuck",     Stuck,  e.stuck);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    pend_ok = 1'b0;
    last_per = 0;
    last_hi  = 0;
    Reset   = 1'b0;
    PWM_in  = 1'b0;
    repeat (3) @(negedge CLK);
    chk_outputs_zero("rst");
    Reset = 1'b1;
    repeat (5) @(negedge CLK);

    repeat (5) drive_period(64, 16);
    drive_period(64, 8);
    drive_period(64, 7);
    drive_period(80, 79);
    drive_period(2, 1);
    drive_period(2, 1);
    drive_period(TO, TO / 2);
    drive_period(64, 16);
    drive_stuck_high();
    drive_period(64, 32);
    drive_period(64, 32);

    // Rising edge whose result is discarded by a mid-period reset.
    @(negedge CLK);
    PWM_in = 1'b1;
    repeat (2) @(negedge CLK);
    chk("pre_rst_period", Period, 64);
    #2 Reset = 1'b0;
    #1 chk_outputs_zero("async_rst");
    PWM_in  = 1'b0;
    pend_ok = 1'b0;
    repeat (4) @(negedge CLK);
    Reset = 1'b1;
    repeat (5) @(negedge CLK);

    drive_period(64, 16);
    drive_period(64, 24);
    drive_period(64, 40);
    repeat (20) @(negedge CLK);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16, width of the period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 65535, number of CLK cycles without a rising edge after which the input is declared stuck; must be ≤ 2^CNT_W-1.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 PWM_in  input  1  asynchronous PWM line; the same waveform signaalGenerator-style transmitters emit.
REQ-006 Level  output  3  decoded duty level 0..7, the inverse of the value-to-PWM mapping.
REQ-007 Period  output  CNT_W  last measured period in CLK cycles.
REQ-008 High  output  CNT_W  last measured high time in CLK cycles.
REQ-009 Valid  output  1  one-cycle pulse when Level/Period/High are updated.
REQ-010 Stuck  output  1  high while the line is considered stuck (no rising edge for TIMEOUT cycles).

Function
REQ-011 PWM_in SHALL pass through a 2-flop synchronizer; rising/falling edges are detected on the synchronized signal, giving rise_det and fall_det one cycle later.
REQ-012 FSM states SHALL be IDLE, MEASURE, STUCK; reset state is IDLE.
REQ-013 IDLE: ignore fall_det; on rise_det clear counters and go to MEASURE; no Valid issued.
REQ-014 MEASURE: per_cnt increments every cycle; hi_cnt increments every cycle the synchronized signal is 1; counting includes the cycle of rise_det as count 1.
REQ-015 MEASURE, on rise_det: Period<=per_cnt, High<=hi_cnt, Level<=computed level, Valid=1 for exactly the next cycle; counters restart at 1 (hi_cnt at 1) in the same cycle, so no cycle is lost between periods.
REQ-016 Level SHALL be the largest k in 0..7 with High*8 >= k*Period (i.e. floor(8*High/Period)), computed with CNT_W+3-bit unsigned compares, no divider.
REQ-017 MEASURE, per_cnt reaching TIMEOUT with no rise_det: go to STUCK, set Stuck=1, Level=7 if synchronized line is 1 else 0, Period and High unchanged, Valid pulse once.
REQ-018 STUCK: counters held; on rise_det clear Stuck, clear counters to 1, go to MEASURE; next Valid only after one full period.
REQ-019 Counters SHALL never wrap: TIMEOUT guarantees transition to STUCK before overflow.
REQ-020 Simultaneous rise_det and timeout in the same cycle: rise_det wins (normal measurement, no Stuck).
REQ-021 Valid latency: 4 CLK edges after the PWM_in rising edge is first sampled (2 sync + 1 edge detect + 1 output register).

Reset
REQ-022 Reset low SHALL asynchronously force IDLE, counters 0, synchronizer flops 0, Level=0, Period=0, High=0, Valid=0, Stuck=0.
REQ-023 Reset asserted mid-measurement discards the partial period; after release the first Valid requires two rising edges.
REQ-024 Reset release takes effect on the next CLK rising edge; outputs glitch-free (all registered).

Structure
REQ-025 Shared package pwm_pkg SHALL hold CNT_W default, LEVEL_W=3, and the FSM state enum (IDLE, MEASURE, STUCK).
REQ-026 Synchronizer plus edge detector SHALL be one sub-module, pwm_edge_sync (ports CLK, Reset, d, q, rise, fall).
REQ-027 Level comparator bank is combinational inside pwm_capture; all outputs registered.

Verification
REQ-028 Period 64, high 16, repeated 5 periods -> from 2nd rising edge: Valid once per 64 cycles, Period=64, High=16, Level=2.
REQ-029 Period 64, high 8 then high 7 -> Level=1 then Level=0 (boundary 64>=64 vs 56<64).
REQ-030 PWM_in held 1 after one period, TIMEOUT=1000 -> Stuck=1 and Level=7 exactly 1000 cycles after last rise_det, single Valid; then resume period 64/high 32 -> Stuck=0, next Valid one period later, Level=4.
REQ-031 Period 80, high 79 -> Level=7; period 2, high 1 -> Level=4.
REQ-032 Reset pulsed low mid-period while Valid pending -> all outputs 0 immediately (asynchronously), first Valid after the second subsequent rising edge.
REQ-033 rise_det forced in the same cycle per_cnt=TIMEOUT -> normal Valid with Period=TIMEOUT, Stuck stays 0.
